ripple_addsub_seq_64bit: RTL and testbench

Sequenced 64-bit add/subtract unit built around the existing combinational `Ripple_Carry_Addr_64bit` adder. It accepts operands over a valid/ready handshake and registers them onto the adder inputs. It then waits a programmable number of cycles for the ripple carry chain to settle, captures the sum, carry and status flags, and presents them downstream over a second valid/ready handshake. It is the stage that feeds the adder and consumes its output, so the combinational adder can sit in a clocked datapath without being timing-critical.

---
 rtl/ripple_addsub_seq_64bit.sv | 145 ++++++++++++++
 tb/tb_ripple_addsub_seq_64bit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_addsub_seq_64bit.sv
// rtl/ripple_addsub_seq_64bit.sv - sequenced 64-bit add/subtract around a ripple-carry adder

module Ripple_Carry_Addr_64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        cin,
    output logic [63:0] S,
    output logic        cout
);
    logic carry;

    // Carry threaded through a procedural variable so the chain stays one ripple path.
    always_comb begin
        S     = '0;
        carry = cin;
        for (int i = 0; i < 64; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        cout = carry;
    end
endmodule

module ripple_addsub_seq_64bit #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;

    logic [63:0] sum;
    logic        cout;

    Ripple_Carry_Addr_64bit u_adder (
        .A    (a_q),
        .B    (b_q),
        .cin  (cin_q),
        .S    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1, so the adder itself never needs a mode pin.
                    a_d     = op_a;
                    b_d     = op_b ^ {64{sub}};
                    cin_d   = sub;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = sum;
                    carry_d  = cout;
                    ovf_d    = (a_q[63] == b_q[63]) && (sum[63] != a_q[63]);
                    zero_d   = (sum == 64'd0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs come from registered state; rst only masks in_ready during reset.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_ripple_addsub_seq_64bit.sv
// tb/tb_ripple_addsub_seq_64bit.sv - scoreboard bench for ripple_addsub_seq_64bit

module tb_ripple_addsub_seq_64bit;
    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, sub = 1'b0;
    logic [63:0] op_a = '0, op_b = '0, result;
    logic        out_valid, out_ready = 1'b0, carry_out, overflow, zero;

    logic        b_in_valid = 1'b0, b_in_ready, b_sub = 1'b0;
    logic [63:0] b_op_a = '0, b_op_b = '0, b_result;
    logic        b_out_valid, b_out_ready = 1'b0, b_carry_out, b_overflow, b_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t bq[$];

    always #5 clk = ~clk;

    ripple_addsub_seq_64bit #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    ripple_addsub_seq_64bit #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op_a(b_op_a), .op_b(b_op_b), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .carry_out(b_carry_out), .overflow(b_overflow), .zero(b_zero)
    );

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [64:0] w;
        exp_t        e;
        if (!s) begin
            w   = {1'b0, a} + {1'b0, b};
            e.c = w[64];
            e.v = (a[63] == b[63]) && (w[63] != a[63]);
        end else begin
            w   = {1'b0, a - b};
            e.c = (a >= b);
            e.v = (a[63] != b[63]) && (w[63] != a[63]);
        end
        e.r = w[63:0];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
        int n = 0;
        in_valid = 1'b1; op_a = a; op_b = b; sub = s;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        q.push_back(model(a, b, s));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(output exp_t got);
        int   n = 0;
        exp_t e;
        got = '0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL collect_timeout: out_valid=%b required 1", out_valid);
            return;
        end
        got = {result, carry_out, overflow, zero};
        e   = (q.size() != 0) ? q.pop_front() : '0;
        if (got !== e) begin
            errors++;
            $display("FAIL scoreboard: got r=%h c=%b v=%b z=%b required r=%h c=%b v=%b z=%b",
                     got.r, got.c, got.v, got.z, e.r, e.c, e.v, e.z);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({in_ready, out_valid, result, carry_out, overflow, zero} !== 68'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h flags=%b%b%b required all 0",
                     in_ready, out_valid, result, carry_out, overflow, zero);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b/%b required 1/1", in_ready, b_in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        exp_t got;
        issue(64'd100, 64'd24, 1'b0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL add_early_%0d: out_valid=%b in_ready=%b required 0/0", k, out_valid, in_ready);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: out_valid=%b required 1", out_valid);
        end
        collect(got);
        checks++;
        if (got !== {64'd124, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_value: r=%h c=%b v=%b z=%b required 124 0 0 0", got.r, got.c, got.v, got.z);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub;
        exp_t got;
        issue(64'd34, 64'd57, 1'b1);
        collect(got);
        checks++;
        if (got.r !== 64'hFFFF_FFFF_FFFF_FFE9 || got.c !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg: r=%h c=%b required ffffffffffffffe9 0", got.r, got.c);
        end
        issue(64'd98, 64'd40, 1'b1);
        collect(got);
        checks++;
        if (got.r !== 64'd58 || got.c !== 1'b1) begin
            errors++;
            $display("FAIL sub_pos: r=%h c=%b required 3a 1", got.r, got.c);
        end
    endtask

    task automatic test_wrap;
        exp_t got;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect(got);
        checks++;
        if (got !== {64'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_zero: r=%h c=%b v=%b z=%b required 0 1 0 1", got.r, got.c, got.v, got.z);
        end
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect(got);
        checks++;
        if (got !== {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_ovf: r=%h c=%b v=%b z=%b required 8000000000000000 0 1 0",
                     got.r, got.c, got.v, got.z);
        end
    endtask

    task automatic test_backpressure;
        exp_t snap, e, got;
        int   n = 0;
        issue(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        snap = {result, carry_out, overflow, zero};
        e    = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || snap !== e) begin
            errors++;
            $display("FAIL bp_first: out_valid=%b r=%h required 1 r=%h", out_valid, snap.r, e.r);
        end
        in_valid = 1'b1; op_a = 64'd5; op_b = 64'd7; sub = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({result, carry_out, overflow, zero} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: r=%h out_valid=%b in_ready=%b required r=%h 1 0",
                         k, result, out_valid, in_ready, e.r);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== e.r) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b r=%h required 0 1 r=%h",
                     out_valid, in_ready, result, e.r);
        end
        @(posedge clk);
        q.push_back(model(64'd5, 64'd7, 1'b0));
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b required 0", in_ready);
        end
        collect(got);
        checks++;
        if (got.r !== 64'd12) begin
            errors++;
            $display("FAIL bp_second_value: r=%h required c", got.r);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        issue(64'd9, 64'd3, 1'b0);
        void'(q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, result, carry_out, overflow, zero} !== 68'd0) begin
            errors++;
            $display("FAIL rst_mid_state: in_ready=%b out_valid=%b result=%h flags=%b%b%b required all 0",
                     in_ready, out_valid, result, carry_out, overflow, zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_abort: out_valid cycles=%0d in_ready=%b required 0 1", seen, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int   issued = 0, got_n = 0, last = -1, gap_err = 0;
        logic prev_ready;
        exp_t g, e;
        b_out_ready = 1'b1;
        b_op_a = {$urandom, $urandom}; b_op_b = {$urandom, $urandom}; b_sub = 1'($urandom);
        b_in_valid = 1'b1;
        prev_ready = b_in_ready;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (prev_ready && b_in_valid) begin
                bq.push_back(model(b_op_a, b_op_b, b_sub));
                issued++;
                b_op_a = {$urandom, $urandom}; b_op_b = {$urandom, $urandom}; b_sub = 1'($urandom);
                if (issued == 8) b_in_valid = 1'b0;
            end
            if (b_out_valid) begin
                g = {b_result, b_carry_out, b_overflow, b_zero};
                e = (bq.size() != 0) ? bq.pop_front() : '0;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL b2b_value_%0d: r=%h c=%b v=%b z=%b required r=%h c=%b v=%b z=%b",
                             got_n, g.r, g.c, g.v, g.z, e.r, e.c, e.v, e.z);
                end
                if (last == cyc - 1) gap_err++;
                last = cyc;
                got_n++;
            end
            prev_ready = b_in_ready;
        end
        b_out_ready = 1'b0;
        checks++;
        if (got_n != 8 || gap_err != 0) begin
            errors++;
            $display("FAIL b2b_count: results=%0d stretched=%0d required 8 0", got_n, gap_err);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_wrap;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
